multicycle_adder: RTL

MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

---
 rtl/multicycle_adder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_adder.sv
// -----------------------------------------------------------------------------
// multicycle_adder
//
// Purpose:
//   Adds or subtracts two WIDTH-bit two's-complement operands SLICE bits per
//   clock cycle, LSB slice first, taking K = WIDTH/SLICE cycles per operation.
//   Flags (carryout, overflow, zero) are produced on the final slice and held,
//   together with sum, until the next accepted start.
//
// Configuration macro:
//   MULTICYCLE_ADDER_SATURATE_EN - when defined, a signed overflow clamps sum to
//   the most positive / most negative value (chosen by the sign of a).
//   When undefined, sum is the wrapped WIDTH-bit result.
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous active-high reset (priority over start)
//   start     in   1      request a new operation (accepted in IDLE or DONE)
//   subtract  in   1      0 = a+b, 1 = a-b
//   a, b      in   WIDTH  operands
//   busy      out  1      operation in progress
//   done      out  1      one-cycle result-valid pulse
//   sum       out  WIDTH  result (partial bits visible while busy)
//   carryout  out  1      carry out of the MSB (1 = no borrow on subtract)
//   overflow  out  1      signed overflow
//   zero      out  1      final sum equals zero
// -----------------------------------------------------------------------------
module multicycle_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned K  = WIDTH / SLICE;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             busy_q;
  logic             done_q;
  logic             carryout_q;
  logic             overflow_q;
  logic             zero_q;

  logic [31:0]      base_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH-1:0] a_shift_s;
  logic [WIDTH-1:0] b_shift_s;
  logic [SLICE-1:0] a_sl_s;
  logic [SLICE-1:0] b_sl_s;
  logic [SLICE:0]   add_s;
  logic             cin_msb_s;
  logic             last_s;
  logic [WIDTH-1:0] slice_mask_s;
  logic [WIDTH-1:0] sum_d;
  logic             overflow_d;
  logic [WIDTH-1:0] final_d;

  // Slice datapath: select the current slice, add it, and merge it into sum.
  always_comb begin
    base_s       = 32'(cnt_q) * 32'(SLICE);
    b_eff_s      = sub_q ? ~b_q : b_q;
    a_shift_s    = a_q >> base_s;
    b_shift_s    = b_eff_s >> base_s;
    a_sl_s       = a_shift_s[SLICE-1:0];
    b_sl_s       = b_shift_s[SLICE-1:0];
    add_s        = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{SLICE{1'b0}}, carry_q};
    // On the final slice the sum bit at the MSB is a^b^cin, so cin is recoverable.
    cin_msb_s    = a_sl_s[SLICE-1] ^ b_sl_s[SLICE-1] ^ add_s[SLICE-1];
    overflow_d   = cin_msb_s ^ add_s[SLICE];
    last_s       = (cnt_q == CW'(K - 1));
    slice_mask_s = WIDTH'({SLICE{1'b1}}) << base_s;
    sum_d        = (sum_q & ~slice_mask_s) | (WIDTH'(add_s[SLICE-1:0]) << base_s);
`ifdef MULTICYCLE_ADDER_SATURATE_EN
    if (overflow_d) begin
      final_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      final_d = sum_d;
    end
`else
    final_d = sum_d;
`endif
  end

  // Control FSM with registered outputs and operand/result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      sub_q      <= 1'b0;
      carry_q    <= 1'b0;
      cnt_q      <= {CW{1'b0}};
      sum_q      <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= subtract;
            carry_q <= subtract;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          carry_q <= add_s[SLICE];
          if (last_s) begin
            sum_q      <= final_d;
            carryout_q <= add_s[SLICE];
            overflow_q <= overflow_d;
            zero_q     <= (final_d == {WIDTH{1'b0}});
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else begin
            sum_q   <= sum_d;
            cnt_q   <= cnt_q + CW'(1);
            state_q <= RUN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule
